// File: rtl/window_gen_5x5_pkg.sv
// Shared constants for the 5x5 window generator and the downstream
// Gaussian convolution stage.
//   KERNEL_SIZE : window edge length in pixels
//   PIX_W       : greyscale pixel width
//   WINDOW_W    : packed window width (KERNEL_SIZE^2 * PIX_W)
//   WIN_ROW_W   : width of one packed window row
package window_gen_5x5_pkg;

  localparam int unsigned KERNEL_SIZE = 5;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned WINDOW_W    = KERNEL_SIZE * KERNEL_SIZE * PIX_W;
  localparam int unsigned WIN_ROW_W   = KERNEL_SIZE * PIX_W;

endpackage

// File: rtl/window_gen_5x5_line_delay.sv
// line_delay: one image line of delay built from a circular-address RAM.
// Each enabled edge writes din at the current slot and advances the
// pointer; dout is the combinational read of that same slot, i.e. the
// sample written exactly DEPTH enabled edges earlier.
// Storage is never cleared; only the pointer is reset.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high, resets the address pointer only
//   en    : shift enable (one sample in, one sample out)
//   din   : sample written this edge
//   dout  : sample from DEPTH enabled edges ago
module line_delay #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    addr;

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (en) begin
      addr <= (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/window_gen_5x5.sv
// window_gen_5x5: builds a sliding 5x5 pixel window from a raster stream
// for the Gaussian convolution stage.
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous active-high; clears position, window, conv_en
//   pixel_in    : 8-bit greyscale pixel in raster order
//   pixel_valid : pixel_in accepted on edges where high; low stalls everything
//   sof         : start of frame, qualified by pixel_valid (row 0, col 0)
//   pixel_data  : packed window, index k = 5*i + j at bits [8k+7:8k],
//                 i = 0 oldest row .. 4 newest, j = 0 oldest col .. 4 newest
//   conv_en     : pixel_data holds a full in-frame window this cycle
module window_gen_5x5
  import window_gen_5x5_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PIX_W-1:0]    pixel_in,
  input  logic                pixel_valid,
  input  logic                sof,
  output logic [WINDOW_W-1:0] pixel_data,
  output logic                conv_en
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  // Position of the next pixel expected in the frame.
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  // Position of the pixel presented this cycle; sof forces the origin.
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;

  // taps[0] is the current row, taps[k] the same column k lines earlier.
  logic [KERNEL_SIZE-1:0][PIX_W-1:0] taps;
  logic [WINDOW_W-1:0]               window_q;

  always_comb begin
    cur_col = sof ? '0 : col;
    cur_row = sof ? '0 : row;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (pixel_valid) begin
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  assign taps[0] = pixel_in;

  for (genvar k = 0; k < KERNEL_SIZE - 1; k++) begin : g_line
    line_delay #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PIX_W)
    ) u_line_delay (
      .clk   (clk),
      .reset (reset),
      .en    (pixel_valid),
      .din   (taps[k]),
      .dout  (taps[k+1])
    );
  end

  // Each packed window row shifts toward j = 0; the newest column enters
  // at j = 4. Window row i takes the tap that is (4 - i) lines old.
  always_ff @(posedge clk) begin
    if (reset) begin
      window_q <= '0;
    end else if (pixel_valid) begin
      for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
        window_q[i*WIN_ROW_W +: WIN_ROW_W] <=
          {taps[KERNEL_SIZE-1-i], window_q[i*WIN_ROW_W+PIX_W +: WIN_ROW_W-PIX_W]};
      end
    end
  end

  // Window is complete only once the accepted pixel sits at row >= 4 and
  // col >= 4 of the current frame; this also masks stale line contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_en <= 1'b0;
    end else begin
      conv_en <= pixel_valid
                 && (cur_row >= RW'(KERNEL_SIZE - 1))
                 && (cur_col >= CW'(KERNEL_SIZE - 1));
    end
  end

  assign pixel_data = window_q;

endmodule

// File: tb/tb_window_gen_5x5.sv
module tb_window_gen_5x5;

  localparam int W = 8;
  localparam int H = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   pixel_in = '0;
  logic         pixel_valid = 1'b0;
  logic         sof = 1'b0;
  logic [199:0] pixel_data;
  logic         conv_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  window_gen_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .sof         (sof),
    .pixel_data  (pixel_data),
    .conv_en     (conv_en)
  );

  // Reference model: the frame as an image array indexed by position.
  logic [7:0]   img [H][W];
  int           m_row = 0;
  int           m_col = 0;
  logic         exp_en = 1'b0;
  logic [199:0] exp_data = '0;
  logic         have_data = 1'b0;

  task automatic step(input logic v, input logic s, input logic [7:0] p, input logic rst);
    int r, c;
    reset = rst; pixel_valid = v; sof = s; pixel_in = p;
    @(posedge clk);
    if (rst) begin
      m_row = 0; m_col = 0;
      exp_en = 1'b0; exp_data = '0; have_data = 1'b1;
    end else if (v) begin
      r = s ? 0 : m_row;
      c = s ? 0 : m_col;
      img[r][c] = p;
      exp_en = (r >= 4) && (c >= 4);
      have_data = exp_en;
      if (exp_en) begin
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            exp_data[8*(5*i+j) +: 8] = img[r-4+i][c-4+j];
      end
      c = c + 1;
      if (c == W) begin
        c = 0;
        r = (r == H - 1) ? 0 : r + 1;
      end
      m_row = r; m_col = c;
    end else begin
      exp_en = 1'b0;
    end
    #1;
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(16 * r + c);
  endfunction

  task automatic test_reset;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (conv_en !== 1'b0) begin
      errors++; $display("FAIL reset_conv_en: got %b expected 0", conv_en);
    end
    checks++;
    if (pixel_data !== '0) begin
      errors++; $display("FAIL reset_pixel_data: got %h expected 0", pixel_data);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_frame;
    int pulses = 0;
    logic [199:0] last_win = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, (r == 0 && c == 0), pix(r, c), 1'b0);
        checks++;
        if (conv_en !== exp_en) begin
          errors++; $display("FAIL frame_conv_en r%0d c%0d: got %b expected %b", r, c, conv_en, exp_en);
        end
        if (exp_en) begin
          checks++;
          if (pixel_data !== exp_data) begin
            errors++; $display("FAIL frame_window r%0d c%0d: got %h expected %h", r, c, pixel_data, exp_data);
          end
        end
        if (conv_en === 1'b1) begin
          if (pulses == 0) begin
            checks++;
            if (pixel_data[7:0] !== 8'h00 || pixel_data[103:96] !== 8'h22 ||
                pixel_data[199:192] !== 8'h44 || pix(r, c) !== 8'h44) begin
              errors++;
              $display("FAIL frame_first_window: at pix %h got idx0=%h idx12=%h idx24=%h expected 44: 00 22 44",
                       pix(r, c), pixel_data[7:0], pixel_data[103:96], pixel_data[199:192]);
            end
          end
          pulses++;
          last_win = pixel_data;
        end
      end
    end
    checks++;
    if (pulses !== 8) begin
      errors++; $display("FAIL frame_pulses: got %0d expected 8", pulses);
    end
    checks++;
    if (last_win[7:0] !== 8'h13 || last_win[199:192] !== 8'h57) begin
      errors++; $display("FAIL frame_last_window: got idx0=%h idx24=%h expected 13 57", last_win[7:0], last_win[199:192]);
    end
  endtask

  task automatic test_stall;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, (r == 0 && c == 0), pix(r, c), 1'b0);
        checks++;
        if (conv_en !== exp_en || (have_data && pixel_data !== exp_data)) begin
          errors++; $display("FAIL stall_window r%0d c%0d: got %b/%h expected %b/%h", r, c, conv_en, pixel_data, exp_en, exp_data);
        end
        if (r == 4 && c == 5) begin
          for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 8'hEE, 1'b0);
            checks++;
            if (conv_en !== 1'b0) begin
              errors++; $display("FAIL stall_conv_en gap%0d: got %b expected 0", g, conv_en);
            end
            checks++;
            if (pixel_data !== exp_data) begin
              errors++; $display("FAIL stall_hold gap%0d: got %h expected %h", g, pixel_data, exp_data);
            end
          end
        end
      end
    end
  endtask

  task automatic test_sof_mid;
    int pulses = 0;
    for (int k = 0; k < 3 * W + 2; k++) begin
      step(1'b1, (k == 0), pix(k / W, k % W), 1'b0);
      checks++;
      if (conv_en !== 1'b0) begin
        errors++; $display("FAIL sof_mid_old_frame k%0d: got %b expected 0", k, conv_en);
      end
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, (r == 0 && c == 0), pix(r, c), 1'b0);
        checks++;
        if (conv_en !== exp_en || (exp_en && pixel_data !== exp_data)) begin
          errors++; $display("FAIL sof_mid_window r%0d c%0d: got %b/%h expected %b/%h", r, c, conv_en, pixel_data, exp_en, exp_data);
        end
        if (conv_en === 1'b1) pulses++;
        if (r == 4 && c == 4) begin
          checks++;
          if (pulses !== 1) begin
            errors++; $display("FAIL sof_mid_first_pulse: got %0d pulses at r4c4 expected 1", pulses);
          end
        end
      end
    end
    checks++;
    if (pulses !== 8) begin
      errors++; $display("FAIL sof_mid_pulses: got %0d expected 8", pulses);
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    for (int k = 0; k <= 5 * W; k++)
      step(1'b1, (k == 0), pix(k / W, k % W), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (conv_en !== 1'b0 || pixel_data !== '0) begin
      errors++; $display("FAIL reset_mid_clear: got %b/%h expected 0/0", conv_en, pixel_data);
    end
    // Following frame carries no sof: reset alone restarts at the origin.
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, 1'b0, pix(r, c), 1'b0);
        checks++;
        if (conv_en !== exp_en || (exp_en && pixel_data !== exp_data)) begin
          errors++; $display("FAIL reset_mid_window r%0d c%0d: got %b/%h expected %b/%h", r, c, conv_en, pixel_data, exp_en, exp_data);
        end
        if (conv_en === 1'b1) pulses++;
      end
    end
    checks++;
    if (pulses !== 8) begin
      errors++; $display("FAIL reset_mid_pulses: got %0d expected 8", pulses);
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          step(1'b1, (r == 0 && c == 0), pix(r, c), 1'b0);
          checks++;
          if (conv_en !== exp_en || (exp_en && pixel_data !== exp_data)) begin
            errors++; $display("FAIL b2b_window f%0d r%0d c%0d: got %b/%h expected %b/%h", f, r, c, conv_en, pixel_data, exp_en, exp_data);
          end
          if (conv_en === 1'b1) begin
            pulses++;
            if (pulses == 9) begin
              checks++;
              if (pixel_data[199:192] !== 8'h44 || pixel_data[7:0] !== 8'h00) begin
                errors++; $display("FAIL b2b_second_first: got idx24=%h idx0=%h expected 44 00", pixel_data[199:192], pixel_data[7:0]);
              end
            end
          end
        end
      end
    end
    checks++;
    if (pulses !== 16) begin
      errors++; $display("FAIL b2b_pulses: got %0d expected 16", pulses);
    end
  endtask

  task automatic test_random;
    logic v, s, rst;
    for (int n = 0; n < 600; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      s   = v && ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step(v, s, 8'($urandom), rst);
      checks++;
      if (conv_en !== exp_en) begin
        errors++; $display("FAIL random_conv_en n%0d: got %b expected %b", n, conv_en, exp_en);
      end
      if (have_data) begin
        checks++;
        if (pixel_data !== exp_data) begin
          errors++; $display("FAIL random_window n%0d: got %h expected %h", n, pixel_data, exp_data);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_stall;
    test_sof_mid;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_gen_5x5.md
WINDOW_GEN_5X5 -- requirements
Module: window_gen_5x5

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 480, meaning active lines per frame.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port pixel_in, input, 8 bits, greyscale pixel in raster order.
REQ-006 The block SHALL have port pixel_valid, input, 1 bit; pixel_in is accepted on any clk edge where it is high.
REQ-007 The block SHALL have port sof, input, 1 bit, start of frame, qualified by pixel_valid; marks the pixel at row 0, col 0.
REQ-008 The block SHALL have port pixel_data, output, 200 bits, 5x5 window for the downstream Gaussian convolution stage.
REQ-009 The block SHALL have port conv_en, output, 1 bit; pixel_data is a valid full window in the cycle this is high.

Function
REQ-010 The block SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) giving the position of each accepted pixel.
REQ-011 The block SHALL advance col by one per accepted pixel, wrapping IMG_WIDTH-1 -> 0 and incrementing row on the wrap.
REQ-012 The block SHALL wrap row from IMG_HEIGHT-1 to 0 on the last pixel of a frame.
REQ-013 An accepted pixel with sof high SHALL be treated as row 0, col 0, overriding counter state, including mid-frame.
REQ-014 The block SHALL delay the pixel stream through four cascaded one-line delays of IMG_WIDTH entries, giving the vertical taps rows r, r-1, r-2, r-3, r-4.
REQ-015 The block SHALL hold a 5x5 register window that shifts one column per accepted pixel, taking the five vertical taps as its newest column.
REQ-016 The line delays and window SHALL NOT shift when pixel_valid is low (stall), and SHALL keep their contents.
REQ-017 The block SHALL pack pixel_data with index k = 5*i + j at bits [8k+7:8k], where i = 0 is the oldest row, i = 4 the newest, j = 0 the oldest column, and j = 4 the newest.
REQ-018 pixel_data and conv_en SHALL be registered, with one cycle latency from the accepting edge of the window's bottom-right pixel.
REQ-019 conv_en SHALL be high exactly for accepted pixels with row >= 4 and col >= 4 in the current frame, so there is no window across a line or frame boundary.
REQ-020 conv_en SHALL be low in the cycle after any edge where pixel_valid is low; pixel_data then holds its last value.
REQ-021 The block SHALL produce exactly (IMG_WIDTH-4)*(IMG_HEIGHT-4) conv_en pulses per complete frame.

Reset
REQ-022 On reset, col, row, conv_en and pixel_data SHALL be set to 0 on the next clk edge.
REQ-023 On reset, line-delay storage SHALL NOT be cleared; the row/col gating makes stale contents unobservable.
REQ-024 A reset asserted mid-frame SHALL abandon the frame; the next accepted pixel is row 0, col 0 whether or not sof is high.

Structure
REQ-025 A shared package SHALL hold KERNEL_SIZE=5, PIX_W=8 and WINDOW_W=200, used by this block and the convolution stage.
REQ-026 A one-line delay SHALL be a sub-module named line_delay (depth IMG_WIDTH, 8-bit, enable-gated, circular-address RAM), instantiated four times.

Verification (bench IMG_WIDTH=8, IMG_HEIGHT=6, pixel value = 16*row + col)
REQ-027 Continuous frame with sof on the first pixel -> the first conv_en comes one cycle after accepting 0x44, with pixel_data index 0 = 0x00, index 12 = 0x22 and index 24 = 0x44.
REQ-028 The same frame -> 8 conv_en pulses in total, and the last window has index 0 = 0x13 and index 24 = 0x57.
REQ-029 pixel_valid held low for 3 cycles between pixels 0x45 and 0x46 -> conv_en is low for those 3 cycles, and the 0x46 window matches the no-gap run.
REQ-030 sof reasserted at frame position row 3, col 2 -> no conv_en until that new frame reaches row 4, col 4.
REQ-031 reset pulsed after pixel 0x50 -> conv_en = 0 and pixel_data = 0 next cycle, and the following frame output equals the clean-run output.
REQ-032 Two back-to-back frames with no gap -> 16 pulses, and the second frame's first window has index 24 = 0x44 and index 0 = 0x00.
